// File: rtl/four_byte_transmitter_tx_if.sv
// Handshake and serial-line bundle for the four-byte UART transmitter.
// The host side drives the word and request; the transmitter drives the line.
interface four_byte_transmitter_tx_if;
  logic [31:0] i_Tx_Four_Bytes;
  logic        i_Tx_DV;
  logic        o_Tx_Active;
  logic        o_Tx_Serial;
  logic        o_Tx_Byte_Done;
  logic        o_Tx_Done;

  modport master (
    output i_Tx_Four_Bytes,
    output i_Tx_DV,
    input  o_Tx_Active,
    input  o_Tx_Serial,
    input  o_Tx_Byte_Done,
    input  o_Tx_Done
  );

  modport slave (
    input  i_Tx_Four_Bytes,
    input  i_Tx_DV,
    output o_Tx_Active,
    output o_Tx_Serial,
    output o_Tx_Byte_Done,
    output o_Tx_Done
  );
endinterface

// File: rtl/four_byte_transmitter_tx.sv
// Sends one 32-bit word as four 8N1 bytes, MSB byte first, LSB bit first.
// All outputs are registered; the line changes on the same edge as the state.
module four_byte_transmitter_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int GAP_BITS     = 0
) (
  input  logic CLK_25MHZ,
  input  logic RSTN,
  four_byte_transmitter_tx_if.slave tx
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int GW = $clog2(GAP_BITS + 1) + 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_q, clk_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          bdone_q, bdone_d;
  logic          done_q, done_d;

  logic [7:0]    cur_byte;
  logic          last_clk;

  assign cur_byte = shreg_q[{byte_q, 3'b000} +: 8];
  assign last_clk = (clk_q == CLK_LAST);

  always_comb begin
    state_d  = state_q;
    clk_d    = clk_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    gap_d    = gap_q;
    shreg_d  = shreg_q;
    serial_d = 1'b1;
    active_d = active_q;
    bdone_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        active_d = 1'b0;
        if (tx.i_Tx_DV) begin
          shreg_d  = tx.i_Tx_Four_Bytes;
          byte_d   = 2'd3;
          clk_d    = '0;
          state_d  = START;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end

      START: begin
        serial_d = 1'b0;
        if (last_clk) begin
          clk_d    = '0;
          bit_d    = 3'd0;
          state_d  = DATA;
          serial_d = cur_byte[0];
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end

      DATA: begin
        serial_d = cur_byte[bit_q];
        if (last_clk) begin
          clk_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = cur_byte[bit_q + 3'd1];
          end
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end

      STOP: begin
        if (last_clk) begin
          clk_d   = '0;
          bdone_d = 1'b1;
          if (byte_q == 2'd0) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            active_d = 1'b0;
          end else begin
            byte_d = byte_q - 2'd1;
            // With no gap the next start bit follows the stop bit directly
            if (GAP_BITS == 0) begin
              state_d  = START;
              serial_d = 1'b0;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end

      GAP: begin
        if (last_clk) begin
          clk_d = '0;
          if (gap_q == GAP_LAST) begin
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      clk_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      gap_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      bdone_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_q    <= clk_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      gap_q    <= gap_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      active_q <= active_d;
      bdone_q  <= bdone_d;
      done_q   <= done_d;
    end
  end

  assign tx.o_Tx_Serial    = serial_q;
  assign tx.o_Tx_Active    = active_q;
  assign tx.o_Tx_Byte_Done = bdone_q;
  assign tx.o_Tx_Done      = done_q;

endmodule
